hex_disp_ctrl: RTL

Parametrised, time-multiplexed driver for a common-anode multi-digit 7-segment display showing an NUM_DIGITS-digit hex value. Performs the hex-to-segment decode on board, with leading-zero blanking and tear-free, frame-synchronous value updates. Sits between datapath/status logic and the board display pins.

---
 rtl/hex_disp_pkg.sv | 26 ++
 rtl/hex_seg_lut.sv | 31 +++
 rtl/hex_disp_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/hex_disp_pkg.sv
// Shared constants for the multiplexed hex display driver: segment width,
// the all-off pattern and the active-low {g,f,e,d,c,b,a} glyphs for 0..F.
package hex_disp_pkg;

   localparam int SEG_W = 7;

   localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

   localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
   localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
   localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
   localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
   localparam logic [SEG_W-1:0] SEG_6 = 7'b0000010;
   localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;
   localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
   localparam logic [SEG_W-1:0] SEG_9 = 7'b0010000;
   localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
   localparam logic [SEG_W-1:0] SEG_B = 7'b0000011;
   localparam logic [SEG_W-1:0] SEG_C = 7'b1000110;
   localparam logic [SEG_W-1:0] SEG_D = 7'b0100001;
   localparam logic [SEG_W-1:0] SEG_E = 7'b0000110;
   localparam logic [SEG_W-1:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/hex_seg_lut.sv
// Combinational hex nibble to active-low 7-segment glyph decoder.
module hex_seg_lut
   import hex_disp_pkg::*;
(
   input  logic [3:0]       digit,
   output logic [SEG_W-1:0] seg
);

   always_comb begin
      seg = SEG_OFF;
      case (digit)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
      endcase
   end

endmodule

// File: rtl/hex_disp_ctrl.sv
// Time-multiplexed common-anode hex display driver with leading-zero blanking
// and frame-synchronous value commit. Optional blinking with HEX_DISP_BLINK_EN.
module hex_disp_ctrl
   import hex_disp_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int BLINK_DIV  = 64
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    blank_lz,
`ifdef HEX_DISP_BLINK_EN
   input  logic                    blink,
`endif
   output logic [SEG_W-1:0]        seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int PRESC_W = $clog2(SCAN_DIV);
   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || SCAN_DIV < 2 || BLINK_DIV < 1) begin : g_bad_params
      $error("hex_disp_ctrl: parameter out of range");
   end

   logic [PRESC_W-1:0]      presc;
   logic [IDX_W-1:0]        idx;
   logic                    tick;
   logic                    wrap;
   logic [4*NUM_DIGITS-1:0] disp_value;
   logic [4*NUM_DIGITS-1:0] pend_value;
   logic                    disp_blz;
   logic                    pend_blz;
   logic                    pend_valid;
   logic [3:0]              cur_digit;
   logic                    lz_run;
   logic                    blank_slot;
   logic [SEG_W-1:0]        lut_seg;
   logic                    dark;

   assign tick = (presc == PRESC_W'(SCAN_DIV - 1));
   assign wrap = tick && (idx == IDX_W'(NUM_DIGITS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc <= '0;
         idx   <= '0;
      end else if (tick) begin
         presc <= '0;
         idx   <= wrap ? '0 : idx + 1'b1;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   // The displayed copy only changes on a frame wrap, so a frame never mixes digits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp_value <= '0;
         disp_blz   <= 1'b0;
         pend_value <= '0;
         pend_blz   <= 1'b0;
         pend_valid <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (wrap && load) begin
            disp_value <= value;
            disp_blz   <= blank_lz;
            pend_valid <= 1'b0;
            frame_done <= 1'b1;
         end else if (wrap && pend_valid) begin
            disp_value <= pend_value;
            disp_blz   <= pend_blz;
            pend_valid <= 1'b0;
            frame_done <= 1'b1;
         end else if (load) begin
            pend_value <= value;
            pend_blz   <= blank_lz;
            pend_valid <= 1'b1;
         end
      end
   end

   // lz_run stays set while every digit from the top down to i is zero.
   always_comb begin
      cur_digit  = 4'h0;
      lz_run     = disp_blz;
      blank_slot = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         lz_run = lz_run && (disp_value[4*i +: 4] == 4'h0);
         if (idx == IDX_W'(i)) begin
            cur_digit  = disp_value[4*i +: 4];
            blank_slot = lz_run && (i != 0);
         end
      end
   end

   hex_seg_lut u_lut (
      .digit (cur_digit),
      .seg   (lut_seg)
   );

`ifdef HEX_DISP_BLINK_EN
   localparam int FRAME_W = $clog2(2 * BLINK_DIV);

   logic [FRAME_W-1:0] frame_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt <= '0;
      end else if (wrap) begin
         frame_cnt <= (frame_cnt == FRAME_W'(2 * BLINK_DIV - 1)) ? '0 : frame_cnt + 1'b1;
      end
   end

   assign dark = blink && (frame_cnt >= FRAME_W'(BLINK_DIV));
`else
   assign dark = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg <= SEG_OFF;
         an  <= '1;
      end else if (blank_slot || dark) begin
         seg <= SEG_OFF;
         an  <= '1;
      end else begin
         seg <= lut_seg;
         an  <= ~(NUM_DIGITS'(1) << idx);
      end
   end

endmodule
